// File: rtl/riscv_pkg.sv
// Shared RV32 front-end constants: default widths, reset PC and the canonical NOP.
package riscv_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          ADDR_W_DEF   = 8;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/inst_fetch.sv
// PC / fetch stage in front of a 1-cycle synchronous instruction ROM.
// Emits a valid-tagged (pc, inst) pair and handles decode stall and branch redirect.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_inst,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_inst,
  output logic              misalign_err
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] inst_hold_q, inst_hold_d;
  logic            hold_sel_q, hold_sel_d;
  logic            misalign_err_q, misalign_err_d;

  always_comb begin
    pc_d           = pc_q;
    resp_pc_d      = resp_pc_q;
    resp_valid_d   = resp_valid_q;
    inst_hold_d    = inst_hold_q;
    hold_sel_d     = hold_sel_q;
    misalign_err_d = 1'b0;
    if (redirect_valid) begin
      // Squash whatever the ROM is returning this cycle; refetch from the word-aligned target.
      pc_d           = {redirect_pc[XLEN-1:2], 2'b00};
      resp_valid_d   = 1'b0;
      hold_sel_d     = 1'b0;
      misalign_err_d = |redirect_pc[1:0];
    end else if (stall) begin
      // The ROM keeps reading pc_q, which is one ahead of the presented pair, so the
      // presented instruction must be captured on the first stalled edge only.
      if (!hold_sel_q) begin
        inst_hold_d = rom_inst;
        hold_sel_d  = 1'b1;
      end
    end else begin
      pc_d         = pc_q + XLEN'(4);
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      hold_sel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      resp_pc_q      <= '0;
      resp_valid_q   <= 1'b0;
      inst_hold_q    <= XLEN'(NOP_INST);
      hold_sel_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      resp_pc_q      <= resp_pc_d;
      resp_valid_q   <= resp_valid_d;
      inst_hold_q    <= inst_hold_d;
      hold_sel_q     <= hold_sel_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign rom_addr     = pc_q[ADDR_W+1:2];
  assign if_valid     = resp_valid_q;
  assign if_pc        = resp_pc_q;
  assign if_inst      = !resp_valid_q ? XLEN'(NOP_INST) : (hold_sel_q ? inst_hold_q : rom_inst);
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: ROM model, a PC-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM preloaded with inst[i] = A000_0000 + i.
  logic [31:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
  end
  always @(posedge clk) rom_inst <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which PC is next to fetch, which PC is being presented, and
  // the instruction that must accompany it, derived from the ROM contents directly.
  logic [31:0] m_next_pc, m_out_pc;
  logic        m_valid, m_mis;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_next_pc = 32'h0; m_out_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
      chk_en = 1;
    end else if (redirect_valid) begin
      m_next_pc = redirect_pc & ~32'h3;
      m_valid   = 1'b0;
      m_mis     = (redirect_pc[1:0] != 2'b00);
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      m_out_pc  = m_next_pc;
      m_next_pc = m_next_pc + 32'd4;
      m_valid   = 1'b1;
      m_mis     = 1'b0;
    end
  end

  function automatic logic [31:0] model_inst();
    if (!m_valid) return NOP;
    return 32'hA000_0000 + {24'h0, m_out_pc[9:2]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("m_if_inst", if_inst, model_inst());
      chk("m_rom_addr", {24'b0, rom_addr}, {24'b0, m_next_pc[9:2]});
      chk("m_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
      if (m_valid) chk("m_if_pc", if_pc, m_out_pc);
      $display("cyc t=%0t rst=%0b stall=%0b redir=%0b rpc=%h | v=%0b pc=%h inst=%h ra=%h mis=%0b",
               $time, rst, stall, redirect_valid, redirect_pc, if_valid, if_pc, if_inst, rom_addr,
               misalign_err);
    end
  end

  // Returns after the next falling edge, i.e. once one rising edge has consumed the inputs.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pair(input string name, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({name, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) chk({name, "_pc"}, if_pc, pc);
    chk({name, "_inst"}, if_inst, inst);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    // Reset state
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_rom_addr", {24'b0, rom_addr}, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;

    // 1: free run from reset
    tick(); pair("t1_c1", 1'b1, 32'h0, 32'hA000_0000);
    tick(); pair("t1_c2", 1'b1, 32'h4, 32'hA000_0001);
    tick(); pair("t1_c3", 1'b1, 32'h8, 32'hA000_0002);

    // 2: stall 3 cycles at pc 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); pair("t2_stall", 1'b1, 32'h8, 32'hA000_0002);
    end
    stall = 1'b0;
    tick(); pair("t2_release", 1'b1, 32'hC, 32'hA000_0003);

    // 3: redirect to 0x40
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); pair("t3_bubble", 1'b0, 32'h0, NOP);
    redirect_valid = 1'b0;
    tick(); pair("t3_target", 1'b1, 32'h40, 32'hA000_0010);

    // 4: misaligned redirect with concurrent stall
    redirect_valid = 1'b1; redirect_pc = 32'h42; stall = 1'b1;
    tick(); pair("t4_bubble", 1'b0, 32'h0, NOP);
    chk("t4_mis_hi", {31'b0, misalign_err}, 32'd1);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(); pair("t4_target", 1'b1, 32'h40, 32'hA000_0010);
    chk("t4_mis_lo", {31'b0, misalign_err}, 32'd0);

    // Back-to-back redirects: only the last target is fetched
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); pair("b2b_1", 1'b0, 32'h0, NOP);
    redirect_pc = 32'h100;
    tick(); pair("b2b_2", 1'b0, 32'h0, NOP);
    redirect_valid = 1'b0;
    tick(); pair("b2b_target", 1'b1, 32'h100, 32'hA000_0040);

    // 5: ROM address wrap
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    tick(); chk("t5_ra_ff", {24'b0, rom_addr}, 32'hFF);
    redirect_valid = 1'b0;
    tick(); pair("t5_3fc", 1'b1, 32'h3FC, 32'hA000_00FF);
    chk("t5_ra_00", {24'b0, rom_addr}, 32'h00);
    tick(); pair("t5_400", 1'b1, 32'h400, 32'hA000_0000);

    // 6: reset during a stall at pc 0x10
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    tick(); pair("t6_pre", 1'b1, 32'h10, 32'hA000_0004);
    stall = 1'b1;
    tick(); pair("t6_stall", 1'b1, 32'h10, 32'hA000_0004);
    rst = 1'b1;
    tick(); pair("t6_rst", 1'b0, 32'h0, NOP);
    chk("t6_rst_pc", if_pc, 32'h0);
    chk("t6_rst_ra", {24'b0, rom_addr}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    tick(); pair("t6_restart0", 1'b1, 32'h0, 32'hA000_0000);
    tick(); pair("t6_restart1", 1'b1, 32'h4, 32'hA000_0001);

    // Mixed directed pattern, checked by the per-cycle model
    for (int i = 0; i < 24; i++) begin
      stall          = (i % 5 == 1) || (i % 5 == 2) || (i == 13);
      redirect_valid = (i == 7) || (i == 12) || (i == 18) || (i == 19);
      redirect_pc    = 32'h200 + 32'(i * 12) + 32'(i % 4);
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
